// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared encodings for the two-port memory arbiter
package mem_arb_pkg;

  localparam int LAT_CNT_W = 3;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    DONE   = 2'b10
  } arb_state_t;

  typedef enum logic {
    OWN_I = 1'b0,
    OWN_D = 1'b1
  } owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - combinational two-way round-robin pick between I and D
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic i_req,
  input  logic d_req,
  input  logic last_gnt,
  output logic grant_valid,
  output logic grant_owner
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant_owner = OWN_I;
    if (i_req && d_req) begin
      // On a tie the requester that did not win last time goes first.
      grant_owner = ~last_gnt;
    end else if (d_req) begin
      grant_owner = OWN_D;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares one synchronous RAM port between the I-fill and D-cache paths
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int A_WIDTH = 8,
  parameter int D_WIDTH = 16,
  parameter int MEM_LAT = 2
) (
  input  logic               g_clk,
  input  logic               g_clr,
  input  logic               i_req,
  input  logic [A_WIDTH-1:0] i_addr,
  output logic [D_WIDTH-1:0] i_rdata,
  output logic               i_done,
  input  logic               d_req,
  input  logic               d_we,
  input  logic [A_WIDTH-1:0] d_addr,
  input  logic [D_WIDTH-1:0] d_wdata,
  output logic [D_WIDTH-1:0] d_rdata,
  output logic               d_done,
  output logic               mem_en,
  output logic               mem_we,
  output logic [A_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  input  logic [D_WIDTH-1:0] mem_rdata,
  output logic               busy
);

  localparam logic [LAT_CNT_W-1:0] LAT_INIT = LAT_CNT_W'(MEM_LAT - 1);

  arb_state_t             state_q, state_d;
  logic [LAT_CNT_W-1:0]   cnt_q;
  logic                   owner_q;
  logic                   last_gnt_q;
  logic [A_WIDTH-1:0]     addr_q;
  logic                   we_q;
  logic [D_WIDTH-1:0]     wdata_q;
  logic [D_WIDTH-1:0]     i_rdata_q;
  logic [D_WIDTH-1:0]     d_rdata_q;
  logic                   grant_valid;
  logic                   grant_owner;
  logic                   grant;
  logic                   last_cycle;

  rr_arbiter2 u_rr (
    .i_req       (i_req),
    .d_req       (d_req),
    .last_gnt    (last_gnt_q),
    .grant_valid (grant_valid),
    .grant_owner (grant_owner)
  );

  assign grant      = (state_q == IDLE) && grant_valid;
  assign last_cycle = (state_q == ACCESS) && (cnt_q == '0);

  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    i_done    = 1'b0;
    d_done    = 1'b0;
    busy      = 1'b0;
    case (state_q)
      IDLE: begin
        if (grant_valid) state_d = ACCESS;
      end
      ACCESS: begin
        busy      = 1'b1;
        mem_en    = 1'b1;
        mem_we    = we_q;
        mem_addr  = addr_q;
        mem_wdata = wdata_q;
        if (cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        busy    = 1'b1;
        i_done  = (owner_q == OWN_I);
        d_done  = (owner_q == OWN_D);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Request inputs are only looked at on the grant edge; everything after runs from the latches.
  always_ff @(posedge g_clk or negedge g_clr) begin
    if (!g_clr) begin
      cnt_q      <= '0;
      owner_q    <= OWN_D;
      last_gnt_q <= OWN_D;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      i_rdata_q  <= '0;
      d_rdata_q  <= '0;
    end else begin
      if (grant) begin
        owner_q    <= grant_owner;
        last_gnt_q <= grant_owner;
        cnt_q      <= LAT_INIT;
        if (grant_owner == OWN_D) begin
          addr_q  <= d_addr;
          we_q    <= d_we;
          wdata_q <= d_wdata;
        end else begin
          addr_q  <= i_addr;
          we_q    <= 1'b0;
          wdata_q <= '0;
        end
      end else if (state_q == ACCESS && cnt_q != '0) begin
        cnt_q <= cnt_q - 1'b1;
      end

      if (last_cycle && !we_q) begin
        if (owner_q == OWN_D) begin
          d_rdata_q <= mem_rdata;
        end else begin
          i_rdata_q <= mem_rdata;
        end
      end
    end
  end

  assign i_rdata = i_rdata_q;
  assign d_rdata = d_rdata_q;

endmodule
